// File: rtl/lfsr9_chk_if.sv
// Word-stream port of the 9-bit XNOR dither checker: stimulus side (master)
// and checker side (slave), plus the checker's status and counters.
interface lfsr9_chk_if #(
  parameter int CNT_W = 16
);
  logic             en;
  logic             vld;
  logic [5:0]       urn6b;
  logic             clr;
  logic             lock;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic [1:0]       dbg_state;

  // vld qualifies urn6b for one cycle; there is no back-pressure, every
  // vld word is consumed at the edge that samples it.
  modport master (
    output en, vld, urn6b, clr,
    input  lock, err, err_cnt, word_cnt, dbg_state
  );
  modport slave (
    input  en, vld, urn6b, clr,
    output lock, err, err_cnt, word_cnt, dbg_state
  );
endinterface

// File: rtl/lfsr9_chk.sv
// Receive-side checker for the 9-bit XNOR dither LFSR: self-synchronises a
// shadow register from incoming words, then predicts and scores each word.
module lfsr9_chk #(
  parameter int ERR_THR = 4,
  parameter int CNT_W   = 16
) (
  input logic         CLK,
  input logic         NRST,
  lfsr9_chk_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [3:0] THR = 4'(ERR_THR);

  state_t           state;
  logic [9:1]       h;
  logic [3:0]       fill;
  logic [3:0]       consec;
  logic             lock_q;
  logic             err_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CNT_W-1:0] word_cnt_q;

  logic             fb;
  logic [5:0]       exp_w;
  logic [5:0]       diff;
  logic [2:0]       pop;
  logic [9:1]       h_absorb;
  logic [CNT_W+2:0] err_sum;
  logic [CNT_W-1:0] err_sat;
  logic [CNT_W-1:0] word_sat;

  always_comb begin
    fb       = ~(h[9] ^ h[5]);
    exp_w    = {h[5:1], fb};
    diff     = bus.urn6b ^ exp_w;
    h_absorb = {h[8:1], bus.urn6b[0]};
    pop      = '0;
    for (int i = 0; i < 6; i++) pop = pop + 3'(diff[i]);
    err_sum  = {3'b000, err_cnt_q} + (CNT_W+3)'(pop);
    err_sat  = (err_sum > {3'b000, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
    word_sat = (word_cnt_q == {CNT_W{1'b1}}) ? word_cnt_q : word_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state      <= IDLE;
      h          <= '0;
      fill       <= '0;
      consec     <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      err_q <= 1'b0;
      if (!bus.en) begin
        state  <= IDLE;
        h      <= '0;
        fill   <= '0;
        consec <= '0;
        lock_q <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= SEARCH;
          SEARCH: if (bus.vld) begin
            h <= h_absorb;
            if (fill == 4'd8) begin
              fill <= '0;
              // all-ones is the XNOR lockup state and can never be a valid fill
              if (h_absorb != 9'h1FF) begin
                state  <= LOCKED;
                lock_q <= 1'b1;
              end
            end else begin
              fill <= fill + 1'b1;
            end
          end
          LOCKED: if (bus.vld) begin
            // shadow advances on its own prediction so errors never enter it
            h          <= {h[8:1], fb};
            word_cnt_q <= word_sat;
            if (diff != 6'd0) begin
              err_q     <= 1'b1;
              err_cnt_q <= err_sat;
              if (consec + 4'd1 == THR) begin
                state  <= SEARCH;
                consec <= '0;
                lock_q <= 1'b0;
              end else begin
                consec <= consec + 1'b1;
              end
            end else begin
              consec <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (bus.clr) begin
        err_cnt_q  <= '0;
        word_cnt_q <= '0;
      end
    end
  end

  assign bus.lock      = lock_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_lfsr9_chk.sv
// Bench for lfsr9_chk: two instances (wide counters / ERR_THR=4 and
// 4-bit counters / ERR_THR=15) share one stimulus stream and are scored
// against a bit-history model of the dither sequence.
module tb_lfsr9_chk;
  logic CLK;
  logic NRST;

  lfsr9_chk_if #(.CNT_W(16)) ifa ();
  lfsr9_chk_if #(.CNT_W(4))  ifb ();

  lfsr9_chk #(.ERR_THR(4),  .CNT_W(16)) dut_a (.CLK(CLK), .NRST(NRST), .bus(ifa));
  lfsr9_chk #(.ERR_THR(15), .CNT_W(4))  dut_b (.CLK(CLK), .NRST(NRST), .bus(ifb));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_bad = 0;

  localparam int M_IDLE = 0, M_SEARCH = 1, M_LOCKED = 2;

  // m_age[k][a] is the sequence bit seen a words ago (a = 1..9)
  int m_mode[2];
  int m_age[2][10];
  int m_fill[2];
  int m_consec[2];
  int m_errc[2];
  int m_wordc[2];
  int m_err[2];
  int g_age[10];

  function automatic int cnt_max(int k);
    return (k == 0) ? 65535 : 15;
  endfunction

  function automatic int thr(int k);
    return (k == 0) ? 4 : 15;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_fill[k] = 0; m_consec[k] = 0;
      m_errc[k] = 0; m_wordc[k] = 0; m_err[k] = 0;
      for (int a = 0; a < 10; a++) m_age[k][a] = 0;
    end
  endtask

  task automatic model_push(int k, int b);
    for (int a = 9; a > 1; a--) m_age[k][a] = m_age[k][a-1];
    m_age[k][1] = b;
  endtask

  task automatic model_step(int k, bit en_i, bit vld_i, logic [5:0] w, bit clr_i);
    int nb, ew, d, ones;
    m_err[k] = 0;
    if (!en_i) begin
      m_mode[k] = M_IDLE; m_fill[k] = 0; m_consec[k] = 0;
      for (int a = 0; a < 10; a++) m_age[k][a] = 0;
    end else if (m_mode[k] == M_IDLE) begin
      m_mode[k] = M_SEARCH;
    end else if (vld_i) begin
      if (m_mode[k] == M_SEARCH) begin
        model_push(k, int'(w[0]));
        m_fill[k]++;
        if (m_fill[k] == 9) begin
          m_fill[k] = 0;
          ones = 0;
          for (int a = 1; a <= 9; a++) ones += m_age[k][a];
          if (ones != 9) m_mode[k] = M_LOCKED;
        end
      end else begin
        nb = 1 ^ (m_age[k][9] ^ m_age[k][5]);
        ew = nb;
        for (int i = 1; i < 6; i++) ew = ew | (m_age[k][i] << i);
        model_push(k, nb);
        d = $countones(w ^ 6'(ew));
        m_wordc[k] = (m_wordc[k] + 1 > cnt_max(k)) ? cnt_max(k) : m_wordc[k] + 1;
        if (d != 0) begin
          m_err[k] = 1;
          m_errc[k] = (m_errc[k] + d > cnt_max(k)) ? cnt_max(k) : m_errc[k] + d;
          m_consec[k]++;
          if (m_consec[k] == thr(k)) begin
            m_mode[k] = M_SEARCH;
            m_consec[k] = 0;
          end
        end else begin
          m_consec[k] = 0;
        end
      end
    end
    if (clr_i) begin
      m_errc[k] = 0;
      m_wordc[k] = 0;
    end
  endtask

  // Reference dither generator: new bit = XNOR of the bits 9 and 5 back,
  // word = six newest bits with the newest in bit 0.
  function automatic logic [5:0] gen_next();
    logic [5:0] w;
    int nb;
    nb = 1 ^ (g_age[9] ^ g_age[5]);
    for (int a = 9; a > 1; a--) g_age[a] = g_age[a-1];
    g_age[1] = nb;
    for (int i = 0; i < 6; i++) w[i] = g_age[i+1][0];
    return w;
  endfunction

  task automatic check_all();
    chk("a_lock",     32'(ifa.lock),     32'(m_mode[0] == M_LOCKED));
    chk("a_err",      32'(ifa.err),      32'(m_err[0]));
    chk("a_err_cnt",  32'(ifa.err_cnt),  32'(m_errc[0]));
    chk("a_word_cnt", 32'(ifa.word_cnt), 32'(m_wordc[0]));
    chk("b_lock",     32'(ifb.lock),     32'(m_mode[1] == M_LOCKED));
    chk("b_err",      32'(ifb.err),      32'(m_err[1]));
    chk("b_err_cnt",  32'(ifb.err_cnt),  32'(m_errc[1]));
    chk("b_word_cnt", 32'(ifb.word_cnt), 32'(m_wordc[1]));
  endtask

  task automatic drive(bit en_i, bit vld_i, logic [5:0] w, bit clr_i);
    ifa.en = en_i; ifa.vld = vld_i; ifa.urn6b = w; ifa.clr = clr_i;
    ifb.en = en_i; ifb.vld = vld_i; ifb.urn6b = w; ifb.clr = clr_i;
  endtask

  task automatic cycle(bit en_i, bit vld_i, logic [5:0] w, bit clr_i);
    drive(en_i, vld_i, w, clr_i);
    model_step(0, en_i, vld_i, w, clr_i);
    model_step(1, en_i, vld_i, w, clr_i);
    @(negedge CLK);
    check_all();
  endtask

  task automatic gclean();
    cycle(1'b1, 1'b1, gen_next(), 1'b0);
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_a_lock"}, 32'(ifa.lock), 32'd0);
    chk({tag, "_a_err"},  32'(ifa.err),  32'd0);
    chk({tag, "_a_ecnt"}, 32'(ifa.err_cnt),  32'd0);
    chk({tag, "_a_wcnt"}, 32'(ifa.word_cnt), 32'd0);
    chk({tag, "_b_lock"}, 32'(ifb.lock), 32'd0);
    chk({tag, "_b_ecnt"}, 32'(ifb.err_cnt),  32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] w;
    for (int a = 0; a < 10; a++) g_age[a] = 0;
    g_age[1] = 1;
    model_reset();
    NRST = 1'b0;
    drive(1'b0, 1'b0, 6'd0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    chk_zero_outputs("reset");
    NRST = 1'b1;

    // IDLE -> SEARCH, then nine words to acquire lock
    cycle(1'b1, 1'b0, 6'd0, 1'b0);
    repeat (8) gclean();
    chk("lock_before_9th", 32'(ifa.lock), 32'd0);
    gclean();
    chk("lock_after_9th", 32'(ifa.lock), 32'd1);

    repeat (1000) gclean();
    chk("clean_word_cnt", 32'(ifa.word_cnt), 32'd1000);
    chk("clean_err_cnt",  32'(ifa.err_cnt),  32'd0);

    w = gen_next();
    cycle(1'b1, 1'b1, w ^ 6'h08, 1'b0);
    chk("flip_err_pulse", 32'(ifa.err), 32'd1);
    chk("flip_err_cnt",   32'(ifa.err_cnt), 32'd1);
    chk("flip_lock",      32'(ifa.lock), 32'd1);
    gclean();
    chk("after_flip_clean", 32'(ifa.err), 32'd0);

    w = gen_next();
    cycle(1'b1, 1'b1, ~w, 1'b0);
    chk("invert_err_cnt", 32'(ifa.err_cnt), 32'd7);
    gclean();

    repeat (4) begin
      w = gen_next();
      cycle(1'b1, 1'b1, 6'd0, 1'b0);
    end
    repeat (12) gclean();
    chk("relock", 32'(ifa.lock), 32'd1);

    // isolated single-bit errors with VLD gaps carrying garbage words
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(1, 3)) begin
        if ($urandom_range(0, 2) == 0) cycle(1'b1, 1'b0, 6'($urandom), 1'b0);
        gclean();
      end
      w = gen_next();
      cycle(1'b1, 1'b1, w ^ (6'd1 << $urandom_range(0, 5)), 1'b0);
    end
    chk("sat_b_err_cnt", 32'(ifb.err_cnt), 32'd15);
    chk("sat_a_lock",    32'(ifa.lock), 32'd1);

    w = gen_next();
    cycle(1'b1, 1'b1, w ^ 6'h01, 1'b1);
    chk("clr_a_err_cnt",  32'(ifa.err_cnt),  32'd0);
    chk("clr_a_word_cnt", 32'(ifa.word_cnt), 32'd0);
    chk("clr_b_err_cnt",  32'(ifb.err_cnt),  32'd0);
    gclean();

    cycle(1'b0, 1'b1, 6'($urandom), 1'b0);
    chk("en_low_lock", 32'(ifa.lock), 32'd0);
    cycle(1'b1, 1'b0, 6'd0, 1'b0);
    repeat (12) gclean();
    chk("en_relock", 32'(ifa.lock), 32'd1);

    // asynchronous reset between edges while locked
    #2;
    NRST = 1'b0;
    #1;
    chk_zero_outputs("async_rst");
    model_reset();
    @(negedge CLK);
    NRST = 1'b1;

    repeat (30) cycle(1'b1, 1'b1, 6'h3F, 1'b0);
    chk("lockup_rejected", 32'(ifa.lock), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lfsr9_chk.md
Name: lfsr9_chk

Overview:
- Receive-side checker for the 9-bit XNOR-feedback dither generator's 6-bit word stream (URN6B).
- Self-synchronises a shadow LFSR from the incoming words, then predicts each word and flags mismatches.
- Counts bit errors, counts checked words, and reports lock status.
- Sits at the DSM dither input, or on a loopback/test path, to prove dither integrity in silicon and in simulation.

Parameters:
- ERR_THR, 4: consecutive mismatching words that drop lock (1..15).
- CNT_W, 16: width of ERR_CNT and WORD_CNT; both saturate at all-ones.

Ports:
- CLK  input  1  clock.
- NRST  input  1  reset, asynchronous, active-low.
- EN  input  1  checker enable; low forces IDLE.
- VLD  input  1  URN6B holds a valid word this cycle.
- URN6B  input  6  received word; bit0 is the newest LFSR bit.
- CLR  input  1  synchronous clear of ERR_CNT and WORD_CNT.
- LOCK  output  1  shadow LFSR synchronised.
- ERR  output  1  one-cycle pulse per mismatching word while locked.
- ERR_CNT  output  CNT_W  accumulated bit errors, saturating.
- WORD_CNT  output  CNT_W  words checked while locked, saturating.

Behaviour:
- Reset (NRST low, async): state=IDLE; h[9:1]=0, fill=0, consec=0; LOCK=0, ERR=0, ERR_CNT=0, WORD_CNT=0. All outputs are registered.
- States: IDLE, SEARCH, LOCKED.
- IDLE: entered whenever EN=0, from any state, at the next edge.
  - Clears h, fill and consec.
  - Holds ERR_CNT and WORD_CNT.
  - Leaves to SEARCH at the first edge with EN=1.
- SEARCH: on each VLD word, h <= {h[8:1], URN6B[0]}; fill <= fill+1.
  - When the 9th word is absorbed:
    - if the resulting h != 9'h1FF (the XNOR lockup state), go to LOCKED with fill=0;
    - otherwise restart SEARCH with fill=0.
  - ERR stays 0; counters do not change.
- LOCKED: on each VLD word:
  - fb = ~(h[9]^h[5]); exp = {h[5:1], fb}; diff = URN6B ^ exp.
  - h <= {h[8:1], fb}: the shadow advances on its own prediction, so an error is never copied into it.
  - WORD_CNT increments by 1.
  - diff != 0: ERR=1 next cycle; ERR_CNT += popcount(diff), clamped to 2^CNT_W-1; consec+1.
  - diff == 0: consec=0.
  - consec reaching ERR_THR: go to SEARCH at that edge and clear consec. The ERR pulse and count for that last word still occur.
- Latency: LOCK rises, and ERR pulses, one cycle after the edge that samples the relevant word.
- VLD=0: no state, h, fill or counter changes; ERR=0.
- CLR=1: both counters become 0 at the edge, overriding any increment in the same cycle. State and h are unaffected.
- EN falling mid-LOCKED: LOCK=0 next cycle; counters keep their values.
- Saturation: a counter at all-ones stays there. A partial add that would overflow clamps to all-ones.

Test Plan:
- Generator model seeded 9'd1, EN=1, VLD=1 continuous → LOCK=1 one cycle after the 9th word. Then 1000 clean words → ERR_CNT=0, WORD_CNT=1000, ERR never asserted.
- While locked, flip URN6B[3] on one word → a single ERR pulse, ERR_CNT=1, LOCK stays 1, and the following word is clean (shadow not corrupted).
- While locked, invert all 6 bits of one word → ERR_CNT increments by 6, consec=1, then clears on the next clean word.
- While locked, force URN6B=0 for 4 words (ERR_THR=4) → 4 ERR pulses, LOCK=0 after the 4th. Resume the generator → LOCK=1 again after 9 words.
- CNT_W=4, ERR_THR=15: inject 20 single-bit errors → ERR_CNT=15. Assert CLR in the same cycle as an error → ERR_CNT=0. Toggle VLD low/high mid-stream → no spurious errors.
- Pull NRST low asynchronously mid-LOCKED → LOCK, ERR, ERR_CNT and WORD_CNT are 0 immediately. Feed a constant 6'h3F stream → h=1FF rejected, LOCK stays 0.
